// File: rtl/reg_file_sb_pkg.sv
// regfile_pkg: shared defaults and helpers for the architectural register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and index width
//   nregs(addr_w)           : number of registers addressed by an addr_w index
//   reg_idx_t / reg_data_t  : index and data types at the default widths
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  function automatic int nregs(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_write_decoder.sv
// write_decoder_param: index to one-hot wordline decoder with enable.
//   index    in  ADDR_W           selected line
//   enable   in  1                when low the wordline is all zero
//   wordline out 2**ADDR_W        one-hot of index, gated by enable
module write_decoder_param
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]        index,
  input  logic                     enable,
  output logic [nregs(ADDR_W)-1:0] wordline
);

  // One-hot decode of index, suppressed when not enabled
  always_comb begin
    wordline = '0;
    if (enable) begin
      wordline[index] = 1'b1;
    end else begin
      wordline = '0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: architectural register file with write-through bypass,
// optional hardwired-zero R0 and a per-register busy scoreboard.
//   clk, rst              clock; synchronous active-high reset
//   WriteReg/DstReg/DstData   writeback port
//   SrcReg1/SrcReg2       read indices; SrcData1/SrcData2 combinational data
//   SrcUse1/SrcUse2       qualify source hazards
//   IssueValid/IssueReg   decode issue of a new producer
//   Stall                 RAW/WAW hazard against in-flight producers
//   BusyVec               busy bit per register
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WriteReg,
  input  logic [ADDR_W-1:0]        DstReg,
  input  logic [DATA_W-1:0]        DstData,
  input  logic [ADDR_W-1:0]        SrcReg1,
  input  logic [ADDR_W-1:0]        SrcReg2,
  input  logic                     SrcUse1,
  input  logic                     SrcUse2,
  input  logic                     IssueValid,
  input  logic [ADDR_W-1:0]        IssueReg,
  output logic [DATA_W-1:0]        SrcData1,
  output logic [DATA_W-1:0]        SrcData2,
  output logic                     Stall,
  output logic [nregs(ADDR_W)-1:0] BusyVec
);

  localparam int NUM_REGS = nregs(ADDR_W);

  // R0 can never hold a busy bit when it is hardwired to zero.
  localparam logic [NUM_REGS-1:0] BUSY_MASK =
    ZERO_R0 ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] wr_line;
  logic [NUM_REGS-1:0] iss_line;
  logic [NUM_REGS-1:0] fwd_line;
  logic [NUM_REGS-1:0] beff;
  logic                we;
  logic                iss;

  // Writes to a hardwired R0 are dropped before decode.
  assign we = WriteReg && !(ZERO_R0 && (DstReg == '0));

  write_decoder_param #(.ADDR_W(ADDR_W)) u_wr_dec (
    .index    (DstReg),
    .enable   (we),
    .wordline (wr_line)
  );

  // Without bypass a register being written this cycle still looks busy.
  assign fwd_line = BYPASS ? wr_line : '0;
  assign beff     = busy & ~fwd_line;

  assign Stall = (SrcUse1 && beff[SrcReg1]) ||
                 (SrcUse2 && beff[SrcReg2]) ||
                 (IssueValid && beff[IssueReg]);

  assign iss = IssueValid && !Stall && !(ZERO_R0 && (IssueReg == '0));

  write_decoder_param #(.ADDR_W(ADDR_W)) u_iss_dec (
    .index    (IssueReg),
    .enable   (iss),
    .wordline (iss_line)
  );

  assign BusyVec = busy;

  // Read port 1: zero register, then forwarded writeback, then array
  always_comb begin
    SrcData1 = '0;
    if (ZERO_R0 && (SrcReg1 == '0)) begin
      SrcData1 = '0;
    end else if (fwd_line[SrcReg1]) begin
      SrcData1 = DstData;
    end else begin
      SrcData1 = regs[SrcReg1];
    end
  end

  // Read port 2: zero register, then forwarded writeback, then array
  always_comb begin
    SrcData2 = '0;
    if (ZERO_R0 && (SrcReg2 == '0)) begin
      SrcData2 = '0;
    end else if (fwd_line[SrcReg2]) begin
      SrcData2 = DstData;
    end else begin
      SrcData2 = regs[SrcReg2];
    end
  end

  // Register array and scoreboard update; issue set overrides writeback clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_line[i]) begin
          regs[i] <= DstData;
        end
      end
      busy <= ((busy & ~wr_line) | iss_line) & BUSY_MASK;
    end
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file with an integrated one-hot write decoder, write-through read bypass, optional hardwired-zero R0, and a per-register busy scoreboard. It is the pipeline's architectural register file. Decode stage reads two sources and issues one destination. Writeback stage writes one result. Block raises Stall on RAW/WAW hazards against in-flight producers.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W (derived localparam, not overridable)
ZERO_R0, 1, 1 = register 0 always reads 0, is never written, never busy
BYPASS, 1, 1 = same-cycle writeback data forwarded to reads and clears hazard

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
WriteReg  in  1  writeback enable
DstReg  in  ADDR_W  writeback register index
DstData  in  DATA_W  writeback data
SrcReg1  in  ADDR_W  read port 1 index
SrcReg2  in  ADDR_W  read port 2 index
SrcUse1  in  1  port 1 operand actually consumed (hazard qualify)
SrcUse2  in  1  port 2 operand actually consumed
IssueValid  in  1  decode issues an instruction writing IssueReg
IssueReg  in  ADDR_W  destination of issued instruction
SrcData1  out  DATA_W  read data port 1 (combinational)
SrcData2  out  DATA_W  read data port 2 (combinational)
Stall  out  1  hazard; issue suppressed this cycle (combinational)
BusyVec  out  NUM_REGS  current busy bits, bit i = register i

Behaviour:
- Reset (rst=1 at edge): all registers <= 0, all busy <= 0. Overrides any same-cycle write/issue. After reset: SrcData* = 0, Stall = 0, BusyVec = 0.
- Write decode: wordline = one-hot(DstReg) gated by WriteReg. Effective write: we = WriteReg && !(ZERO_R0 && DstReg==0). On edge, regs[DstReg] <= DstData when we.
- Read, per port n: if ZERO_R0 && SrcRegn==0 -> 0. Else if BYPASS && we && DstReg==SrcRegn -> DstData. Else regs[SrcRegn]. Zero latency.
- Busy effective: beff[i] = busy[i] && !(BYPASS && we && DstReg==i). With BYPASS=0, a register being written this cycle still counts busy.
- Stall = (SrcUse1 && beff[SrcReg1]) || (SrcUse2 && beff[SrcReg2]) || (IssueValid && beff[IssueReg]), covering RAW on either source and WAW on the destination.
- Issue accepted: iss = IssueValid && !Stall && !(ZERO_R0 && IssueReg==0).
- Busy update on edge: clear busy[DstReg] if WriteReg. Then set busy[IssueReg] if iss. Set wins when both target the same register, because the new producer is outstanding.
- WriteReg to a non-busy register is legal. It updates data and busy stays 0.
- ZERO_R0=1: busy[0] constant 0; BusyVec[0]=0; writes to R0 dropped silently.
- SrcReg1==SrcReg2 allowed; both ports return identical data.
- No internal pipeline. Write-to-read latency is 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W constants, function nregs(addr_w) = 2**addr_w, reg_idx_t / reg_data_t typedefs.
- Sub-module write_decoder_param (ADDR_W; in: index, enable; out: 2**ADDR_W one-hot wordline, all-zero when disabled). It is instantiated twice: once for the write wordline, once for the issue-set vector.
- Busy vector and register array live in reg_file_sb.

Test Plan:
- Reset then read all 16 indices -> every SrcData = 0x0000, BusyVec = 0, Stall = 0. Assert rst with WriteReg=1 DstReg=3 DstData=0xBEEF -> R3 still 0 next cycle.
- Write R5=0xA5A5 while SrcReg1=5 same cycle -> SrcData1=0xA5A5 that cycle (BYPASS=1). With BYPASS=0 it reads old value 0, then 0xA5A5 next cycle.
- ZERO_R0=1: write R0=0x1234, IssueValid IssueReg=0 -> SrcData(R0)=0, BusyVec[0]=0, Stall=0.
- Issue R7 (accepted, BusyVec=0x0080). Next cycle SrcUse1=1 SrcReg1=7 -> Stall=1, repeated issue of R2 ignored. Then WriteReg R7=0x0042 with SrcReg1=7 -> Stall=0 (BYPASS=1), SrcData1=0x0042, BusyVec=0 after edge.
- Same cycle WriteReg DstReg=9 and accepted issue IssueReg=9 (busy[9]=0 prior) -> busy[9]=1 after edge (set wins).
- WAW: busy[4]=1, IssueValid IssueReg=4, no writeback -> Stall=1, busy unchanged. Sweep ADDR_W=3 DATA_W=32 -> 8 registers, BusyVec width 8, full write/read of 0xFFFFFFFF.
